// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush controller for a 5-stage MIPS32 pipeline. It combines
// load-use hazards, branch/jump resolution, mult/div occupancy and the
// data-memory handshake into write-enables and flushes for the pipeline
// registers. It owns a two-state memory-wait FSM and a mult/div busy counter.
//
// Parameters:
//   MD_LATENCY  cycles the mult/div unit stays busy after an accepted issue
//   CNT_W       width of the stall-cycle counter output
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   LdUseHazard       load-use hazard from the ID-stage detector
//   ID_Jump           jump decoded in ID
//   EX_BranchTaken    branch resolved taken in EX
//   EX_MdStart        mult/div instruction issuing from EX
//   ID_MdUse          ID instruction reads HI/LO or is itself mult/div
//   MEM_Req           one-cycle pulse: load/store entered MEM
//   MEM_Ready         data memory completes the access
//   PC_Write, IF_ID_Write, EX_MEM_Write    register load enables
//   IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush register flush / bubble controls
//   MdBusy            mult/div unit occupied
//   StallCnt          saturating count of cycles with PC_Write low
//
// Build option: define STALL_CNT_EN to include the stall-cycle counter;
// otherwise StallCnt is tied to zero and no counter register exists.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LdUseHazard,
  input  logic             ID_Jump,
  input  logic             EX_BranchTaken,
  input  logic             EX_MdStart,
  input  logic             ID_MdUse,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCnt
);

  localparam int MD_W = $clog2(MD_LATENCY + 1);
  localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [MD_W-1:0] md_cnt_reg;
  logic [MD_W-1:0] md_cnt_next;
  logic            freeze;
  logic            md_busy_int;
  logic            stall;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      md_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      md_cnt_reg <= md_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Memory-wait FSM. A MEM_Req seen while already waiting is ignored; a
  // zero-wait access (Ready with Req) neither freezes nor changes state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    freeze     = 1'b0;
    case (state_reg)
      RUN: begin
        if (MEM_Req && !MEM_Ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (MEM_Ready) begin
          state_next = RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // -------------------------------------------------------------------------
  // Mult/div busy counter. An issue during freeze is not accepted because the
  // EX instruction is held; the unit itself keeps counting through a freeze.
  // A new issue while busy simply restarts the count.
  // -------------------------------------------------------------------------
  always_comb begin
    md_cnt_next = md_cnt_reg;
    if (EX_MdStart && !freeze) begin
      md_cnt_next = MD_LOAD;
    end else if (md_cnt_reg != '0) begin
      md_cnt_next = md_cnt_reg - MD_W'(1);
    end
  end

  assign md_busy_int = (md_cnt_reg != '0);
  assign stall       = LdUseHazard || (ID_MdUse && md_busy_int);

  // -------------------------------------------------------------------------
  // Pipeline control in strict priority: reset, freeze, taken branch,
  // ID stall, jump, default.
  // -------------------------------------------------------------------------
  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b1;
    MEM_WB_Flush = 1'b0;
    MdBusy       = md_busy_int;
    if (reset) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
      MdBusy       = 1'b0;
    end else if (freeze) begin
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      MEM_WB_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      // The ID instruction is squashed, so any ID-stage stall is moot.
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      // A concurrent jump is dropped here and seen again next cycle.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Optional saturating stall-cycle counter.
  // -------------------------------------------------------------------------
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (!PC_Write && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign StallCnt = stall_cnt_reg;
`else
  assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_stall_ctrl (MD_LATENCY=4, CNT_W=4). Table vectors,
// hand-written multi-cycle sequences and randomized stimulus, all checked
// against a behavioural model of the controller's rules.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int MD_LAT  = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             LdUseHazard, ID_Jump, EX_BranchTaken, EX_MdStart;
  logic             ID_MdUse, MEM_Req, MEM_Ready;
  logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic             EX_MEM_Write, MEM_WB_Flush, MdBusy;
  logic [CNT_W-1:0] StallCnt;

  pipe_stall_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .LdUseHazard(LdUseHazard), .ID_Jump(ID_Jump),
    .EX_BranchTaken(EX_BranchTaken), .EX_MdStart(EX_MdStart),
    .ID_MdUse(ID_MdUse), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Flush(MEM_WB_Flush),
    .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush, MdBusy}
  logic [6:0] dut_flags;
  assign dut_flags = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
                      EX_MEM_Write, MEM_WB_Flush, MdBusy};

  int checks = 0;
  int errors = 0;
  logic [6:0] samp;

  // ---------------- behavioural model ----------------
  bit m_wait;    // a memory access is outstanding
  int m_md;      // cycles of mult/div work remaining
  int m_cnt;     // cycles with PC held

  function automatic void model_reset();
    m_wait = 0; m_md = 0; m_cnt = 0;
  endfunction

  function automatic bit model_freeze();
    return !MEM_Ready && (m_wait || MEM_Req);
  endfunction

  function automatic logic [6:0] model_flags();
    logic busy;
    busy = (m_md > 0);
    if (reset)                             return 7'b0011010;
    if (model_freeze())                    return {6'b000001, busy};
    if (EX_BranchTaken)                    return {6'b111110, busy};
    if (LdUseHazard || (ID_MdUse && busy)) return {6'b000110, busy};
    if (ID_Jump)                           return {6'b111010, busy};
    return {6'b110010, busy};
  endfunction

  function automatic logic [CNT_W-1:0] model_cnt();
`ifdef STALL_CNT_EN
    return CNT_W'(m_cnt);
`else
    return '0;
`endif
  endfunction

  function automatic void model_update();
    bit fr;
    logic [6:0] f;
    if (reset) begin
      model_reset();
      return;
    end
    fr = model_freeze();
    f  = model_flags();
    if (f[6] == 1'b0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    if (EX_MdStart && !fr) m_md = MD_LAT;
    else if (m_md > 0)     m_md = m_md - 1;
    m_wait = fr;
  endfunction

  // ---------------- helpers ----------------
  task automatic drive(input logic [6:0] v);
    {LdUseHazard, ID_Jump, EX_BranchTaken, EX_MdStart,
     ID_MdUse, MEM_Req, MEM_Ready} = v;
  endtask

  task automatic check_model(input string name);
    logic [6:0] ef;
    logic [CNT_W-1:0] ec;
    ef = model_flags();
    ec = model_cnt();
    checks++;
    if (dut_flags !== ef) begin
      errors++;
      $display("FAIL %s flags: got %b expected %b", name, dut_flags, ef);
    end
    checks++;
    if (StallCnt !== ec) begin
      errors++;
      $display("FAIL %s StallCnt: got %0d expected %0d", name, StallCnt, ec);
    end
  endtask

  task automatic expect_flags(input string name, input logic [6:0] exp);
    checks++;
    if (dut_flags !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, dut_flags, exp);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock: sample at negedge, optionally check a fixed expectation,
  // check against the model, then advance the model at the posedge.
  task automatic cycle(input string name, input bit use_exp, input logic [6:0] exp);
    @(negedge clk);
    samp = dut_flags;
    if (use_exp) expect_flags(name, exp);
    check_model(name);
    $display("cyc %s in=%b flags=%b cnt=%0d", name,
             {LdUseHazard, ID_Jump, EX_BranchTaken, EX_MdStart,
              ID_MdUse, MEM_Req, MEM_Ready}, dut_flags, StallCnt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(7'b0);
    reset = 1'b1;
    model_reset();
    cycle("reset", 1'b1, 7'b0011010);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [6:0] in;   // {ld, jmp, br, mdstart, mduse, req, rdy}
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0]  = '{7'b0000000, 7'b1100100};  // idle
    vecs[1]  = '{7'b1000000, 7'b0001100};  // load-use
    vecs[2]  = '{7'b1010000, 7'b1111100};  // load-use + branch
    vecs[3]  = '{7'b0100000, 7'b1110100};  // jump
    vecs[4]  = '{7'b1100000, 7'b0001100};  // jump + load-use
    vecs[5]  = '{7'b1010010, 7'b0000010};  // freeze beats branch/load-use
    vecs[6]  = '{7'b0000011, 7'b1100100};  // zero-wait memory
    vecs[7]  = '{7'b0000100, 7'b1100100};  // HI/LO use, unit idle
    vecs[8]  = '{7'b0000001, 7'b1100100};  // stray ready
    vecs[9]  = '{7'b0001000, 7'b1100100};  // md issue
    vecs[10] = '{7'b0110000, 7'b1111100};  // branch + jump

    drive(7'b0);
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(vecs[i].in);
      cycle($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
      cycle($sformatf("vec%0d_next", i), 1'b0, 7'b0);
    end

    // 3-wait memory access: exactly 3 freeze cycles, release with Ready.
    do_reset();
    n = 0;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0 ? 7'b0000010 : (i == 3 ? 7'b0000001 : 7'b0000000));
      cycle("mem3", 1'b1, (i < 3) ? 7'b0000010 : 7'b1100100);
      if (samp[6] == 1'b0 && samp[1] == 1'b1) n++;
    end
    expect_int("mem3_freeze_count", n, 3);

    // mult/div issue then HI/LO use held: 4 busy/stall cycles.
    do_reset();
    n = 0;
    drive(7'b0001100);
    cycle("md_issue", 1'b1, 7'b1100100);
    for (int i = 0; i < 5; i++) begin
      drive(7'b0000100);
      cycle("md_use", 1'b1, (i < 4) ? 7'b0001101 : 7'b1100100);
      if (samp[0]) n++;
    end
    expect_int("md_busy_count", n, 4);

    // Freeze during busy period does not extend MdBusy.
    do_reset();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      drive(i == 0 ? 7'b0001000 : (i == 1 ? 7'b0000010 : (i == 2 ? 7'b0000001 : 7'b0)));
      cycle("md_freeze", 1'b0, 7'b0);
      if (samp[0]) n++;
    end
    expect_int("md_freeze_busy_count", n, 4);

    // Issue during freeze is not accepted.
    do_reset();
    drive(7'b0001010);
    cycle("md_in_freeze", 1'b1, 7'b0000010);
    drive(7'b0000001);
    cycle("md_in_freeze_rel", 1'b1, 7'b1100100);
    drive(7'b0);
    cycle("md_in_freeze_idle", 1'b1, 7'b1100100);

    // Asynchronous reset mid-MEM_WAIT with mult/div busy.
    do_reset();
    drive(7'b0001000);
    cycle("ar_issue", 1'b0, 7'b0);
    drive(7'b0000010);
    cycle("ar_req", 1'b1, 7'b0000011);
    drive(7'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    expect_flags("async_reset_flags", 7'b0011010);
    expect_int("async_reset_cnt", int'(StallCnt), 0);
    cycle("ar_hold", 1'b1, 7'b0011010);
    reset = 1'b0;
    cycle("ar_release", 1'b1, 7'b1100100);

    // Stall counter saturation: 20 load-use cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(7'b1000000);
      cycle("sat", 1'b1, 7'b0001100);
    end
    drive(7'b0);
    @(negedge clk);
`ifdef STALL_CNT_EN
    expect_int("stallcnt_saturated", int'(StallCnt), 15);
`else
    expect_int("stallcnt_tied_zero", int'(StallCnt), 0);
`endif
    @(posedge clk);
    model_update();
    #1;

    // Randomized stimulus against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (reset) model_reset();
      LdUseHazard    = ($urandom_range(0, 5) == 0);
      ID_Jump        = ($urandom_range(0, 5) == 0);
      EX_BranchTaken = ($urandom_range(0, 6) == 0);
      EX_MdStart     = ($urandom_range(0, 7) == 0);
      ID_MdUse       = ($urandom_range(0, 2) == 0);
      MEM_Req        = ($urandom_range(0, 4) == 0);
      MEM_Ready      = ($urandom_range(0, 2) == 0);
      cycle("rand", 1'b0, 7'b0);
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
